if_prefetch_unit: RTL and testbench
===================================

Name: if_prefetch_unit

Overview:
- Parametrised instruction-fetch front end. Successor to the single-instruction IF stage.
- Integrates a direct-mapped instruction cache, a miss handler with a request/done memory handshake, and BTB-driven next-PC selection.
- Decouples fetch from decode through a QDEPTH-entry instruction queue, and supports redirect/flush and cache invalidation (fence.i).
- Sits between the PC/BTB logic and the memory controller on one side, and the ID stage on the other.

Parameters:
- ADDR_W, 32, instruction address width.
- INST_W, 32, instruction width.
- QDEPTH, 4, instruction queue entries; power of two, at least 2.
- IC_LINES, 64, direct-mapped cache lines of one instruction each; power of two.
- RESET_PC, 0, fetch PC after reset.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- rdy  in  1  global enable; when low, all state is frozen.
- stall_i  in  1  downstream not accepting; blocks pop.
- redirect_e  in  1  branch mispredict or jump resolved; flush and refetch.
- redirect_pc  in  ADDR_W  new fetch address.
- fence_i_e  in  1  invalidate all cache lines.
- mem_req  out  1  fetch request to memory controller.
- mem_addr  out  ADDR_W  request address.
- mem_done  in  1  one-cycle pulse; mem_data is valid.
- mem_data  in  INST_W  fetched word.
- btb_pc  out  ADDR_W  current fetch PC, sent to the BTB.
- btb_hit  in  1  combinational BTB hit for btb_pc.
- btb_pred  in  ADDR_W  predicted target.
- inst_valid  out  1  queue head is valid.
- inst  out  INST_W  head instruction.
- inst_pc  out  ADDR_W  head PC.
- inst_pred_e  out  1  head was predicted taken.
- inst_pred  out  ADDR_W  head predicted next PC.

Behaviour:
- **Reset:**
  - fpc=RESET_PC, state IDLE, queue empty, all cache valid bits cleared.
  - mem_req=0, mem_addr=0, inst_valid=0, inst/inst_pc/inst_pred/inst_pred_e=0.
- **Address split:**
  - index = fpc[log2(IC_LINES)+1:2]; tag = fpc[ADDR_W-1:log2(IC_LINES)+2]; fpc[1:0] ignored.
  - hit = valid[index] && tag match.
- **Next PC:** npc = btb_hit ? btb_pred : fpc+4, with modulo-2^ADDR_W wrap. pred_e = btb_hit.
- **FSM states:** IDLE, MISS (request outstanding), DROP (outstanding request whose result is discarded).
- **IDLE, queue not full:**
  - hit: push {fpc, data, pred_e, npc} and set fpc<=npc. Throughput is one instruction per cycle.
  - miss: go to MISS.
- **IDLE, queue full:** hold fpc; no request issued.
- **MISS:**
  - mem_req=1 and mem_addr=fpc; both are held stable until mem_done.
  - On mem_done: write the cache line (valid=1, tag, data), push the entry with the BTB result for fpc, set fpc<=npc, go to IDLE.
  - A push on mem_done is guaranteed space: entry to MISS requires not-full, and nothing else pushes.
- **DROP:**
  - mem_req=1 and mem_addr=latched old address.
  - On mem_done: fill the cache with that old address and do not push; go to IDLE.
- **mem_done outside MISS/DROP:** ignored.
- **Redirect (highest priority):**
  - Queue emptied, fpc<=redirect_pc, and no push that cycle.
  - From MISS: go to DROP, keeping the outstanding address. From DROP: stay in DROP.
  - If mem_done coincides with redirect in MISS: fill the cache, do not push, go to IDLE.
- **fence_i_e:**
  - Clears all valid bits next cycle.
  - If coincident with a cache fill, the fill is lost (invalidate wins).
  - Does not flush the queue; software redirects as well.
- **Queue:**
  - Pop when inst_valid && !stall_i.
  - Push and pop may occur in the same cycle.
  - Full means count==QDEPTH, evaluated on pre-cycle count; a simultaneous pop does not enable a push.
  - Pointers wrap modulo QDEPTH. Outputs are driven from the head entry (registered storage).
- **Latency:**
  - Hit: inst_valid the cycle after the fetch cycle.
  - Miss: mem_req the cycle after detection; entry visible the cycle after mem_done.
- **rdy=0:** no state update; mem_req/mem_addr hold their values.
- **rst** overrides everything, including a mem request mid-flight. The memory controller is reset by the same rst.

Decomposition:
- Additions to config.v:
  - `IcStateBus` and the state encodings `IC_IDLE`/`IC_MISS`/`IC_DROP`.
  - The queue entry field widths.
- Sub-module if_inst_queue: synchronous FIFO with flush, parametrised by width and QDEPTH, exposing full, empty, head and count.

Test Plan:
- **Cold miss:** reset, mem_done 3 cycles after mem_req with data 0x00000013.
  - Expected: mem_addr=0; entry {pc=0, inst=0x13, pred_e=0, pred=4}; fpc=4.
- **Hit streaming:** loop at 0x0–0xC after fill, stall_i=0.
  - Expected: one inst_valid per cycle; PCs 0,4,8,C repeat; mem_req stays 0.
- **BTB taken:** btb_hit=1, btb_pred=0x100 at fpc=0x8.
  - Expected: entry pred_e=1, pred=0x100; next fetch at 0x100.
- **Queue full:** stall_i=1, all hits.
  - Expected: exactly QDEPTH=4 entries; fpc holds. Releasing stall drains in order with no loss or duplicates.
- **Redirect during miss:** redirect_pc=0x200 two cycles after mem_req at 0x40.
  - Expected: queue empty; FSM enters DROP; at done, line 0x40 is filled with no push; then a fetch request at 0x200.
- **fence.i:** fence_i_e after lines are filled.
  - Expected: the next access to a previously-hit address raises mem_req. With rdy=0 for 5 cycles mid-miss, all outputs stay frozen.

Source files
------------

// File: rtl/if_prefetch_unit_pkg.sv
// Shared types for the instruction prefetch unit: miss-handler state encoding
// and the instruction-queue entry layout.
package if_prefetch_unit_pkg;

   localparam int unsigned IC_STATE_W = 2;

   typedef enum logic [IC_STATE_W-1:0] {
      IC_IDLE = 2'd0,
      IC_MISS = 2'd1,
      IC_DROP = 2'd2
   } ic_state_e;

   // Queue entry is {pc, inst, pred_e, pred}, MSB first.
   function automatic int unsigned qentry_w(input int unsigned addr_w, input int unsigned inst_w);
      return 2 * addr_w + inst_w + 1;
   endfunction

endpackage

// File: rtl/if_inst_queue.sv
// Synchronous FIFO with flush that decouples fetch from decode; head is read
// straight from registered storage.
module if_inst_queue #(
   parameter int unsigned WIDTH = 97,
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       en,
   input  logic                       flush,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   output logic                       full,
   output logic                       empty,
   output logic [WIDTH-1:0]           head,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push, do_pop;

   always_comb begin
      full     = (count_q == (PTR_W+1)'(DEPTH));
      empty    = (count_q == '0);
      do_push  = push && !full && !flush;
      do_pop   = pop && !empty && !flush;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         count_d = count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (en) begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         if (do_push) mem_q[wr_ptr_q] <= push_data;
      end
   end

   assign head  = mem_q[rd_ptr_q];
   assign count = count_q;

endmodule

// File: rtl/if_prefetch_unit.sv
// Instruction-fetch front end: direct-mapped I-cache, miss handler with
// request/done handshake, BTB-driven next PC and a decoupling queue.
module if_prefetch_unit
   import if_prefetch_unit_pkg::*;
#(
   parameter int unsigned          ADDR_W   = 32,
   parameter int unsigned          INST_W   = 32,
   parameter int unsigned          QDEPTH   = 4,
   parameter int unsigned          IC_LINES = 64,
   parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   input  logic              stall_i,
   input  logic              redirect_e,
   input  logic [ADDR_W-1:0] redirect_pc,
   input  logic              fence_i_e,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_done,
   input  logic [INST_W-1:0] mem_data,
   output logic [ADDR_W-1:0] btb_pc,
   input  logic              btb_hit,
   input  logic [ADDR_W-1:0] btb_pred,
   output logic              inst_valid,
   output logic [INST_W-1:0] inst,
   output logic [ADDR_W-1:0] inst_pc,
   output logic              inst_pred_e,
   output logic [ADDR_W-1:0] inst_pred
);

   localparam int unsigned IDX_W   = $clog2(IC_LINES);
   localparam int unsigned TAG_W   = ADDR_W - IDX_W - 2;
   localparam int unsigned ENTRY_W = qentry_w(ADDR_W, INST_W);
   localparam int unsigned CNT_W   = $clog2(QDEPTH) + 1;

   ic_state_e         state_q, state_d;
   logic [ADDR_W-1:0] fpc_q, fpc_d;
   logic [ADDR_W-1:0] req_addr_q, req_addr_d;
   logic [IC_LINES-1:0] valid_q, valid_d;
   logic [TAG_W-1:0]  tag_mem  [IC_LINES];
   logic [INST_W-1:0] data_mem [IC_LINES];

   logic [IDX_W-1:0]  fpc_idx, fill_idx;
   logic [TAG_W-1:0]  fpc_tag, fill_tag;
   logic              hit;
   logic [ADDR_W-1:0] npc;
   logic              fill_en;
   logic              push;
   logic [INST_W-1:0] push_inst;
   logic [ENTRY_W-1:0] push_entry, q_head;
   logic              q_full, q_empty, q_pop;
   logic [CNT_W-1:0]  unused_q_count;

   assign fpc_idx  = fpc_q[IDX_W+1:2];
   assign fpc_tag  = fpc_q[ADDR_W-1:IDX_W+2];
   assign fill_idx = req_addr_q[IDX_W+1:2];
   assign fill_tag = req_addr_q[ADDR_W-1:IDX_W+2];
   assign hit      = valid_q[fpc_idx] && (tag_mem[fpc_idx] == fpc_tag);
   assign npc      = btb_hit ? btb_pred : fpc_q + ADDR_W'(4);

   always_comb begin
      state_d    = state_q;
      fpc_d      = fpc_q;
      req_addr_d = req_addr_q;
      push       = 1'b0;
      push_inst  = data_mem[fpc_idx];
      fill_en    = 1'b0;
      case (state_q)
         IC_IDLE: begin
            if (redirect_e) begin
               fpc_d = redirect_pc;
            end else if (!q_full) begin
               if (hit) begin
                  push  = 1'b1;
                  fpc_d = npc;
               end else begin
                  state_d    = IC_MISS;
                  req_addr_d = fpc_q;
               end
            end
         end
         IC_MISS: begin
            // fpc is frozen while in MISS, so req_addr_q doubles as the fill address.
            push_inst = mem_data;
            if (mem_done) begin
               fill_en = 1'b1;
               state_d = IC_IDLE;
               if (redirect_e) begin
                  fpc_d = redirect_pc;
               end else begin
                  push  = 1'b1;
                  fpc_d = npc;
               end
            end else if (redirect_e) begin
               state_d = IC_DROP;
               fpc_d   = redirect_pc;
            end
         end
         IC_DROP: begin
            if (mem_done) begin
               fill_en = 1'b1;
               state_d = IC_IDLE;
            end
            if (redirect_e) fpc_d = redirect_pc;
         end
         default: state_d = IC_IDLE;
      endcase

      valid_d = valid_q;
      if (fill_en) valid_d[fill_idx] = 1'b1;
      if (fence_i_e) valid_d = '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IC_IDLE;
         fpc_q      <= RESET_PC;
         req_addr_q <= '0;
         valid_q    <= '0;
      end else if (rdy) begin
         state_q    <= state_d;
         fpc_q      <= fpc_d;
         req_addr_q <= req_addr_d;
         valid_q    <= valid_d;
      end
   end

   // Tag/data arrays carry no reset; the valid bits alone gate hits.
   always_ff @(posedge clk) begin
      if (!rst && rdy && fill_en && !fence_i_e) begin
         tag_mem[fill_idx]  <= fill_tag;
         data_mem[fill_idx] <= mem_data;
      end
   end

   assign push_entry = {fpc_q, push_inst, btb_hit, npc};
   assign q_pop      = !q_empty && !stall_i;

   if_inst_queue #(
      .WIDTH (ENTRY_W),
      .DEPTH (QDEPTH)
   ) u_queue (
      .clk       (clk),
      .rst       (rst),
      .en        (rdy),
      .flush     (redirect_e),
      .push      (push),
      .push_data (push_entry),
      .pop       (q_pop),
      .full      (q_full),
      .empty     (q_empty),
      .head      (q_head),
      .count     (unused_q_count)
   );

   assign mem_req    = (state_q != IC_IDLE);
   assign mem_addr   = mem_req ? req_addr_q : '0;
   assign btb_pc     = fpc_q;
   assign inst_valid = !q_empty;
   assign {inst_pc, inst, inst_pred_e, inst_pred} = q_head;

endmodule

// File: tb/tb_if_prefetch_unit.sv
// Directed bench for if_prefetch_unit; memory answers addr ^ 0x13 three
// enabled cycles after a request, BTB maps 0xC->0x0 (and 0x8->0x100 on demand).
module tb_if_prefetch_unit;

   localparam int unsigned MEM_LAT = 3;

   logic        clk, rst, rdy, stall_i, redirect_e, fence_i_e;
   logic [31:0] redirect_pc;
   logic        mem_req, mem_done;
   logic [31:0] mem_addr, mem_data;
   logic [31:0] btb_pc, btb_pred;
   logic        btb_hit, btb2_en;
   logic        inst_valid, inst_pred_e;
   logic [31:0] inst, inst_pc, inst_pred;

   int n_tests = 0;
   int n_fail  = 0;

   if_prefetch_unit #(
      .ADDR_W   (32),
      .INST_W   (32),
      .QDEPTH   (4),
      .IC_LINES (64),
      .RESET_PC (32'h0)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .rdy         (rdy),
      .stall_i     (stall_i),
      .redirect_e  (redirect_e),
      .redirect_pc (redirect_pc),
      .fence_i_e   (fence_i_e),
      .mem_req     (mem_req),
      .mem_addr    (mem_addr),
      .mem_done    (mem_done),
      .mem_data    (mem_data),
      .btb_pc      (btb_pc),
      .btb_hit     (btb_hit),
      .btb_pred    (btb_pred),
      .inst_valid  (inst_valid),
      .inst        (inst),
      .inst_pc     (inst_pc),
      .inst_pred_e (inst_pred_e),
      .inst_pred   (inst_pred)
   );

   assign btb_hit  = (btb_pc == 32'hC) || (btb2_en && btb_pc == 32'h8);
   assign btb_pred = (btb_pc == 32'hC) ? 32'h0 : 32'h100;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin : mem_model
      int cnt;
      cnt      = 0;
      mem_done = 1'b0;
      mem_data = '0;
      forever begin
         @(negedge clk);
         mem_done = 1'b0;
         if (rst || !mem_req) begin
            cnt = 0;
         end else if (rdy) begin
            cnt++;
            if (cnt == MEM_LAT) begin
               mem_done = 1'b1;
               mem_data = mem_addr ^ 32'h13;
               cnt      = 0;
            end
         end
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_for_pc(input string tag, input logic [31:0] pc);
      logic found;
      found = 1'b0;
      for (int n = 0; n < 100 && !found; n++) begin
         tick();
         if (inst_valid && inst_pc == pc) found = 1'b1;
      end
      check(tag, found, 1);
   endtask

   task automatic wait_for_req(input string tag);
      logic found;
      found = mem_req;
      for (int n = 0; n < 100 && !found; n++) begin
         tick();
         found = mem_req;
      end
      check(tag, found, 1);
   endtask

   initial begin
      rst = 1'b1; rdy = 1'b1; stall_i = 1'b0; redirect_e = 1'b0;
      redirect_pc = '0; fence_i_e = 1'b0; btb2_en = 1'b0;
      repeat (3) tick();
      check("rst_mem_req", mem_req, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_inst_valid", inst_valid, 0);
      check("rst_inst", inst, 0);
      check("rst_inst_pc", inst_pc, 0);
      check("rst_pred_e", inst_pred_e, 0);
      check("rst_pred", inst_pred, 0);
      check("rst_fpc", btb_pc, 0);
      rst = 1'b0;

      // cold miss at 0
      tick();
      check("cold_req", mem_req, 1);
      check("cold_addr", mem_addr, 32'h0);
      wait_for_pc("cold_entry_seen", 32'h0);
      check("cold_inst", inst, 32'h13);
      check("cold_pred_e", inst_pred_e, 0);
      check("cold_pred", inst_pred, 32'h4);
      check("cold_fpc", btb_pc, 32'h4);

      // fill 4, 8, C; C predicts back to 0
      wait_for_pc("fill_c_seen", 32'hC);
      check("fill_c_inst", inst, 32'h1F);
      check("fill_c_pred_e", inst_pred_e, 1);
      check("fill_c_pred", inst_pred, 32'h0);

      // hit streaming loop 0..C
      for (int i = 0; i < 8; i++) begin
         tick();
         check("stream_valid", inst_valid, 1);
         check("stream_pc", inst_pc, (i * 4) % 16);
         check("stream_req", mem_req, 0);
      end

      // queue full: head C, then 0,4,8 pushed and fpc held at C
      stall_i = 1'b1;
      repeat (6) tick();
      check("full_valid", inst_valid, 1);
      check("full_head", inst_pc, 32'hC);
      check("full_fpc_hold", btb_pc, 32'hC);
      check("full_req", mem_req, 0);

      // rdy low with stall released: nothing moves
      stall_i = 1'b0;
      rdy     = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("frz_head", inst_pc, 32'hC);
         check("frz_fpc", btb_pc, 32'hC);
      end
      rdy = 1'b1;

      // drain: pop on a full cycle must not admit a push
      tick();
      check("drain_first_head", inst_pc, 32'h0);
      check("drain_no_push", btb_pc, 32'hC);
      for (int i = 1; i < 8; i++) begin
         tick();
         check("drain_valid", inst_valid, 1);
         check("drain_pc", inst_pc, (i * 4) % 16);
      end

      // BTB taken at 8 -> 0x100
      for (int n = 0; n < 50 && btb_pc != 32'h8; n++) tick();
      check("btb_fpc_at_8", btb_pc, 32'h8);
      btb2_en = 1'b1;
      wait_for_pc("btb_entry_seen", 32'h8);
      check("btb_pred_e", inst_pred_e, 1);
      check("btb_pred", inst_pred, 32'h100);
      wait_for_req("btb_req_seen");
      check("btb_req_addr", mem_addr, 32'h100);
      btb2_en = 1'b0;
      wait_for_pc("t100_seen", 32'h100);
      check("t100_inst", inst, 32'h113);
      check("t100_pred", inst_pred, 32'h104);

      // redirect to 0x40, then redirect to 0x200 while 0x40 is outstanding
      redirect_e = 1'b1; redirect_pc = 32'h40;
      tick();
      redirect_e = 1'b0;
      check("rd40_flush", inst_valid, 0);
      check("rd40_fpc", btb_pc, 32'h40);
      tick();
      check("miss40_req", mem_req, 1);
      check("miss40_addr", mem_addr, 32'h40);
      tick();
      redirect_e = 1'b1; redirect_pc = 32'h200;
      tick();
      redirect_e = 1'b0;
      check("drop_req", mem_req, 1);
      check("drop_addr", mem_addr, 32'h40);
      check("drop_fpc", btb_pc, 32'h200);
      check("drop_empty", inst_valid, 0);
      tick();
      check("drop_done_nopush", inst_valid, 0);
      check("drop_done_idle", mem_req, 0);
      tick();
      check("miss200_req", mem_req, 1);
      check("miss200_addr", mem_addr, 32'h200);
      wait_for_pc("t200_seen", 32'h200);
      check("t200_inst", inst, 32'h213);

      // dropped fill at 0x40 must now hit
      redirect_e = 1'b1; redirect_pc = 32'h40;
      tick();
      redirect_e = 1'b0;
      tick();
      check("hit40_valid", inst_valid, 1);
      check("hit40_pc", inst_pc, 32'h40);
      check("hit40_inst", inst, 32'h53);
      check("hit40_req", mem_req, 0);

      // fence.i with redirect to 0: 0 was a hit, now misses
      fence_i_e = 1'b1; redirect_e = 1'b1; redirect_pc = 32'h0;
      tick();
      fence_i_e = 1'b0; redirect_e = 1'b0;
      check("fence_empty", inst_valid, 0);
      check("fence_fpc", btb_pc, 32'h0);
      tick();
      check("fence_req", mem_req, 1);
      check("fence_addr", mem_addr, 32'h0);

      // rdy low mid-miss
      rdy = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("frzm_req", mem_req, 1);
         check("frzm_addr", mem_addr, 32'h0);
         check("frzm_fpc", btb_pc, 32'h0);
         check("frzm_valid", inst_valid, 0);
      end
      rdy = 1'b1;
      wait_for_pc("refill0_seen", 32'h0);
      check("refill0_inst", inst, 32'h13);

      // reset during an outstanding miss at 4
      tick();
      check("miss4_req", mem_req, 1);
      check("miss4_addr", mem_addr, 32'h4);
      rst = 1'b1;
      tick();
      check("rst_mid_req", mem_req, 0);
      check("rst_mid_addr", mem_addr, 32'h0);
      check("rst_mid_fpc", btb_pc, 32'h0);
      check("rst_mid_valid", inst_valid, 0);
      rst = 1'b0;
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
